// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ISA encodings for the single-cycle ARM datapath
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_EOR = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_RSB = 4'h3;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_ADC = 4'h5;
    localparam logic [3:0] ALU_SBC = 4'h6;
    localparam logic [3:0] ALU_RSC = 4'h7;
    localparam logic [3:0] ALU_TST = 4'h8;
    localparam logic [3:0] ALU_TEQ = 4'h9;
    localparam logic [3:0] ALU_CMP = 4'hA;
    localparam logic [3:0] ALU_CMN = 4'hB;
    localparam logic [3:0] ALU_ORR = 4'hC;
    localparam logic [3:0] ALU_MOV = 4'hD;
    localparam logic [3:0] ALU_BIC = 4'hE;
    localparam logic [3:0] ALU_MVN = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Compare/test opcodes only set flags; they never write a destination register.
    function automatic logic is_test_op(input logic [3:0] op);
        return (op == ALU_TST) || (op == ALU_TEQ) || (op == ALU_CMP) || (op == ALU_CMN);
    endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - evaluates an ARM condition field against NZCV flags
module cond_check
    import arm_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Condition-code decode table; NV never executes.
    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            COND_NV: condex = 1'b0;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag register, condition check and write-enable gating
module cond_logic
    import arm_pkg::*;
#(
    parameter int         COND_W      = 4,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              En,
    input  logic [COND_W-1:0] Cond,
    input  logic [1:0]        Op,
    input  logic [3:0]        ALUControl,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              CondEx,
    output logic              CarryIn,
    output logic [3:0]        Flags
);

    logic [3:0] flags_q;
    logic       nowrite;
    logic       issue;

    cond_check u_cond_check (
        .cond   (cond_e'(Cond)),
        .flags  (flags_q),
        .condex (CondEx)
    );

    // Data-processing compares/tests update flags but must not touch the register file.
    assign nowrite = (Op == 2'b00) && is_test_op(ALUControl);
    assign issue   = CondEx & En;

    // Flag register: C/V and N/Z halves update independently; condition uses pre-update value.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAGS_RESET;
        end else if (issue) begin
            if (FlagW[1]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
            if (FlagW[0]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
        end
    end

    // Gate decoder enables by condition pass and instruction advance.
    always_comb begin
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        if (issue) begin
            PCSrc    = PCS;
            RegWrite = RegW & ~nowrite;
            MemWrite = MemW;
        end
    end

    assign CarryIn = flags_q[FLAG_C];
    assign Flags   = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - directed self-checking bench for cond_logic
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset;
    logic       En;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [3:0] ALUControl;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW;
    logic       PCSrc, RegWrite, MemWrite, CondEx, CarryIn;
    logic [3:0] Flags;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    cond_logic #(.COND_W(4), .FLAGS_RESET(4'b0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .En         (En),
        .Cond       (Cond),
        .Op         (Op),
        .ALUControl (ALUControl),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .CondEx     (CondEx),
        .CarryIn    (CarryIn),
        .Flags      (Flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] cond, input logic [1:0] op,
                         input logic [3:0] aluctl, input logic [3:0] aluflags,
                         input logic [1:0] flagw, input logic pcs, input logic regw,
                         input logic memw);
        En = en; Cond = cond; Op = op; ALUControl = aluctl; ALUFlags = aluflags;
        FlagW = flagw; PCS = pcs; RegW = regw; MemW = memw;
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'h0, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);

        // reset state
        @(negedge clk); #1;
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_condex_eq", {3'b0, CondEx}, 4'd0);
        chk("rst_carryin", {3'b0, CarryIn}, 4'd0);

        // AL instruction, all enables pass through
        @(negedge clk); reset = 1'b0;
        drive(1'b1, 4'hE, 2'b01, 4'h4, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1); #1;
        chk("al_pcsrc", {3'b0, PCSrc}, 4'd1);
        chk("al_regwrite", {3'b0, RegWrite}, 4'd1);
        chk("al_memwrite", {3'b0, MemWrite}, 4'd1);
        chk("al_flags", Flags, 4'b0000);

        // CMP sets Z, suppresses register write, update visible next cycle
        @(negedge clk);
        drive(1'b1, 4'hE, 2'b00, 4'hA, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0); #1;
        chk("cmp_regwrite", {3'b0, RegWrite}, 4'd0);
        chk("cmp_condex", {3'b0, CondEx}, 4'd1);
        chk("cmp_flags_pre", Flags, 4'b0000);
        @(negedge clk);
        drive(1'b1, 4'h0, 2'b00, 4'h4, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0); #1;
        chk("cmp_flags_post", Flags, 4'b0100);
        chk("eq_condex", {3'b0, CondEx}, 4'd1);
        chk("eq_regwrite", {3'b0, RegWrite}, 4'd1);
        @(negedge clk);
        drive(1'b1, 4'h1, 2'b00, 4'h4, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0); #1;
        chk("ne_condex", {3'b0, CondEx}, 4'd0);
        chk("ne_regwrite", {3'b0, RegWrite}, 4'd0);

        // NoWrite only for data-processing with compare/test opcode
        @(negedge clk);
        drive(1'b1, 4'hE, 2'b01, 4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0); #1;
        chk("mem_op_regwrite", {3'b0, RegWrite}, 4'd1);
        @(negedge clk);
        drive(1'b1, 4'hE, 2'b00, 4'hC, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0); #1;
        chk("orr_regwrite", {3'b0, RegWrite}, 4'd1);
        @(negedge clk);
        drive(1'b1, 4'hE, 2'b00, 4'h8, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0); #1;
        chk("tst_regwrite", {3'b0, RegWrite}, 4'd0);

        // independent flag halves
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        drive(1'b1, 4'hE, 2'b00, 4'h4, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'hE, 2'b00, 4'h4, 4'b0011, 2'b10, 1'b0, 1'b0, 1'b0); #1;
        chk("nz_only", Flags, 4'b1100);
        chk("nz_only_carry", {3'b0, CarryIn}, 4'd0);
        @(negedge clk);
        drive(1'b1, 4'hE, 2'b00, 4'h4, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0); #1;
        chk("cv_only", Flags, 4'b1111);
        chk("cv_only_carry", {3'b0, CarryIn}, 4'd1);

        // HI / GE / LE spot checks
        @(negedge clk);
        drive(1'b1, 4'h8, 2'b00, 4'h4, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0); #1;
        chk("hi_flags", Flags, 4'b0010);
        chk("hi_pass", {3'b0, CondEx}, 4'd1);
        @(negedge clk);
        drive(1'b1, 4'hE, 2'b00, 4'h4, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'h8, 2'b00, 4'h4, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0); #1;
        chk("hi_fail", {3'b0, CondEx}, 4'd0);
        @(negedge clk);
        drive(1'b1, 4'hE, 2'b00, 4'h4, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'hA, 2'b00, 4'h4, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0); #1;
        chk("ge_pass", {3'b0, CondEx}, 4'd1);
        Cond = 4'hD; #1;
        chk("le_fail", {3'b0, CondEx}, 4'd0);

        // stall: no update, no enables, CondEx still visible
        @(negedge clk);
        drive(1'b0, 4'hE, 2'b00, 4'h4, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1); #1;
        chk("stall_pcsrc", {3'b0, PCSrc}, 4'd0);
        chk("stall_regwrite", {3'b0, RegWrite}, 4'd0);
        chk("stall_memwrite", {3'b0, MemWrite}, 4'd0);
        chk("stall_condex", {3'b0, CondEx}, 4'd1);
        @(negedge clk); #1;
        chk("stall_flags", Flags, 4'b1001);

        // reset beats a valid update
        drive(1'b1, 4'hE, 2'b00, 4'h4, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        drive(1'b1, 4'h0, 2'b00, 4'h4, 4'b0100, 2'b11, 1'b1, 1'b1, 1'b1); #1;
        chk("rst_priority", Flags, 4'b0000);

        // failed condition: no update, no enables
        chk("fail_pcsrc", {3'b0, PCSrc}, 4'd0);
        chk("fail_regwrite", {3'b0, RegWrite}, 4'd0);
        chk("fail_memwrite", {3'b0, MemWrite}, 4'd0);
        @(negedge clk); #1;
        chk("fail_flags_hold", Flags, 4'b0000);

        // full sweep of condition table against every flag state
        for (int f = 0; f < 16; f++) begin
            @(negedge clk);
            drive(1'b1, 4'hE, 2'b00, 4'h4, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            FlagW = 2'b00; #1;
            chk($sformatf("sweep_load_%0d", f), Flags, 4'(f));
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c); #1;
                chk($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, CondEx},
                    {3'b0, ref_cond(4'(c), 4'(f))});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
